// File: rtl/counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_sequencer_if
// Bundles every signal between the counter sequencer, its two clients and the
// shared 4-bit loadable counter. clk and rst are plain ports on the sequencer.
//
//   Client side  : req[1:0], start0/end0, start1/end1, hold      (to sequencer)
//                  grant[1:0], busy, done, done_id               (from sequencer)
//   Counter side : cnt_q                                         (to sequencer)
//                  cnt_enb, cnt_modo, cnt_data                   (from sequencer)
//
// Modports:
//   master : the environment (clients plus counter), drives the requests and Q
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface counter_sequencer_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       req;
  logic [CNT_W-1:0] start0;
  logic [CNT_W-1:0] end0;
  logic [CNT_W-1:0] start1;
  logic [CNT_W-1:0] end1;
  logic             hold;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_enb;
  logic             cnt_modo;
  logic [CNT_W-1:0] cnt_data;
  logic [1:0]       grant;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output req, start0, end0, start1, end1, hold, cnt_q,
    input  cnt_enb, cnt_modo, cnt_data, grant, busy, done, done_id
  );

  modport slave (
    input  req, start0, end0, start1, end1, hold, cnt_q,
    output cnt_enb, cnt_modo, cnt_data, grant, busy, done, done_id
  );
endinterface

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Shares one loadable counter between two clients. A round-robin arbiter picks
// a winner in IDLE, the winner's start value is parallel-loaded into the
// counter (LOAD), the counter is then enabled until its Q equals the winner's
// end value (RUN), and a one-cycle done pulse closes the run (DONE). Dropping
// the owner's req in LOAD or RUN aborts the run without a done pulse.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : counter_sequencer_if.slave (client requests/results, counter pins)
//
// All outputs are decoded from registered state plus cnt_q, hold and req.
// The counter itself is never reset from here; it keeps its value on reset.
// -----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  counter_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             id_q, id_d;          // current owner
  logic             last_id_q, last_id_d;// owner of the last finished/aborted run
  logic [CNT_W-1:0] start_lat_q, start_lat_d;
  logic [CNT_W-1:0] end_lat_q, end_lat_d;

  logic owner_req;
  logic at_end;

  assign owner_req = bus.req[id_q];
  assign at_end    = (bus.cnt_q == end_lat_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;   // client 0 wins the first contention
      start_lat_q <= '0;
      end_lat_q   <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      start_lat_q <= start_lat_d;
      end_lat_q   <= end_lat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    start_lat_d = start_lat_q;
    end_lat_d   = end_lat_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          case (bus.req)
            2'b01:   id_d = 1'b0;
            2'b10:   id_d = 1'b1;
            default: id_d = ~last_id_q;   // both requesting: round-robin
          endcase
          // NOTE: blocking assignment inside combinational logic, so the
          // freshly chosen id_d is visible to the operand select below.
          start_lat_d = id_d ? bus.start1 : bus.start0;
          end_lat_d   = id_d ? bus.end1   : bus.end0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        if (!owner_req) begin
          state_d   = IDLE;
          last_id_d = id_q;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!owner_req) begin
          state_d   = IDLE;
          last_id_d = id_q;
        end else if (at_end) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d   = IDLE;
        last_id_d = id_q;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cnt_enb  = 1'b0;
    bus.cnt_modo = 1'b0;
    bus.cnt_data = '0;
    bus.grant    = 2'b00;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.done_id  = 1'b0;

    if (state_q != IDLE) begin
      bus.grant = id_q ? 2'b10 : 2'b01;
      bus.busy  = 1'b1;
    end

    case (state_q)
      LOAD: begin
        // An owner that withdraws in LOAD never gets the load applied.
        bus.cnt_enb  = owner_req;
        bus.cnt_modo = 1'b1;
        bus.cnt_data = start_lat_q;
      end
      RUN: begin
        // Stop counting on the terminal value, on pause, or on withdrawal.
        bus.cnt_enb = owner_req & ~at_end & ~bus.hold;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.done_id = id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
// Self-checking bench for counter_sequencer. A behavioural 4-bit loadable
// counter closes the loop on cnt_enb/cnt_modo/cnt_data -> cnt_q. Every run the
// stimulus starts pushes its expected completion (owner, done cycle, start and
// end value) into a scoreboard; the monitor pops it when done pulses and
// checks owner, timing, final Q and the number of count enables issued.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  counter_sequencer_if #(.CNT_W(CNT_W)) sif ();

  counter_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Shared counter model; its own reset is tied inactive.
  logic [CNT_W-1:0] ctr_q = '0;
  int               cyc   = 0;

  assign sif.cnt_q = ctr_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sif.cnt_enb) ctr_q <= sif.cnt_modo ? sif.cnt_data : ctr_q + 4'd1;
  end

  typedef struct {
    bit         id;
    int         cyc;
    logic [3:0] st;
    logic [3:0] en;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic expect_done(input bit id, input int c, input logic [3:0] st,
                             input logic [3:0] en);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    e.st  = st;
    e.en  = en;
    sb.push_back(e);
  endtask

  // Input drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until every expected done has been seen.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      check("grant_onehot0", int'($onehot0(sif.grant)), 1);
      if (!sif.cnt_modo) check("data_zero", int'(sif.cnt_data), 0);
      if (sif.cnt_enb && sif.cnt_modo) en_cnt = 0;
      else if (sif.cnt_enb) en_cnt++;
      if (sif.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", int'(sif.done), 0);
        end else begin
          e = sb.pop_front();
          check("done_id",    int'(sif.done_id), int'(e.id));
          check("done_cycle", cyc, e.cyc);
          check("done_q",     int'(sif.cnt_q), int'(e.en));
          check("enables",    en_cnt, (int'(e.en) - int'(e.st)) & 15);
          check("done_grant", int'(sif.grant), e.id ? 2 : 1);
          check("done_busy",  int'(sif.busy), 1);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    int d0, d1, d2, d3;
    int q_at_rst;

    sif.req    = 2'b00;
    sif.start0 = '0;
    sif.end0   = '0;
    sif.start1 = '0;
    sif.end1   = '0;
    sif.hold   = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_grant", int'(sif.grant),    0);
    check("rst_busy",  int'(sif.busy),     0);
    check("rst_done",  int'(sif.done),     0);
    check("rst_did",   int'(sif.done_id),  0);
    check("rst_enb",   int'(sif.cnt_enb),  0);
    check("rst_modo",  int'(sif.cnt_modo), 0);
    check("rst_data",  int'(sif.cnt_data), 0);
    #2 rst = 1'b1;

    // ---- basic run: client 0, 3 -> 7, done 7 cycles after req ----
    tick();
    sif.start0 = 4'd3;
    sif.end0   = 4'd7;
    sif.req    = 2'b01;
    expect_done(1'b0, cyc + 7, 4'd3, 4'd7);
    @(negedge clk);
    @(negedge clk);
    check("load_modo",  int'(sif.cnt_modo), 1);
    check("load_data",  int'(sif.cnt_data), 3);
    check("load_enb",   int'(sif.cnt_enb),  1);
    check("load_grant", int'(sif.grant),    1);
    wait_drain(40);
    sif.req = 2'b00;

    // ---- wrap-around: client 1, 14 -> 1 ----
    tick();
    sif.start1 = 4'd14;
    sif.end1   = 4'd1;
    sif.req    = 2'b10;
    expect_done(1'b1, cyc + 6, 4'd14, 4'd1);
    wait_drain(40);
    sif.req = 2'b00;
    repeat (3) @(negedge clk);
    check("wrap_no_extra", int'(ctr_q), 1);
    check("wrap_idle",     int'(sif.busy), 0);

    // ---- contention: both held, four back-to-back runs alternate ----
    tick();
    sif.start0 = 4'd2;
    sif.end0   = 4'd4;
    sif.start1 = 4'd9;
    sif.end1   = 4'd8;
    sif.req    = 2'b11;
    t  = cyc;
    d0 = t + 3 + 2;
    d1 = d0 + 1 + 3 + 15;
    d2 = d1 + 1 + 3 + 2;
    d3 = d2 + 1 + 3 + 15;
    expect_done(1'b0, d0, 4'd2, 4'd4);
    expect_done(1'b1, d1, 4'd9, 4'd8);
    expect_done(1'b0, d2, 4'd2, 4'd4);
    expect_done(1'b1, d3, 4'd9, 4'd8);
    wait_drain(150);
    sif.req = 2'b00;

    // ---- hold for two cycles mid-run: 0 -> 5 ----
    tick();
    sif.start0 = 4'd0;
    sif.end0   = 4'd5;
    sif.req    = 2'b01;
    t = cyc;
    expect_done(1'b0, t + 10, 4'd0, 4'd5);
    repeat (3) tick();
    sif.hold = 1'b1;
    @(negedge clk);
    check("hold1_enb", int'(sif.cnt_enb), 0);
    check("hold1_q",   int'(ctr_q),       1);
    tick();
    @(negedge clk);
    check("hold2_enb", int'(sif.cnt_enb), 0);
    check("hold2_q",   int'(ctr_q),       1);
    tick();
    sif.hold = 1'b0;
    wait_drain(40);
    sif.req = 2'b00;

    // ---- abort: client 0 withdraws at Q = 4, pending client 1 served ----
    tick();
    sif.start0 = 4'd2;
    sif.end0   = 4'd9;
    sif.req    = 2'b01;
    t = cyc;
    tick();
    sif.start1 = 4'd5;
    sif.end1   = 4'd5;
    sif.req    = 2'b11;
    repeat (3) tick();
    sif.req = 2'b10;
    expect_done(1'b1, t + 8, 4'd5, 4'd5);
    @(negedge clk);
    check("abort_q",     int'(ctr_q),         4);
    check("abort_enb",   int'(sif.cnt_enb),   0);
    check("abort_grant", int'(sif.grant),     1);
    tick();
    @(negedge clk);
    check("abort_idle",  int'(sif.busy),      0);
    check("abort_q_kept", int'(ctr_q),        4);
    wait_drain(40);
    sif.req = 2'b00;

    // ---- asynchronous reset mid-run ----
    tick();
    sif.start0 = 4'd0;
    sif.end0   = 4'd12;
    sif.req    = 2'b01;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    q_at_rst = int'(ctr_q);
    check("arst_grant", int'(sif.grant),   0);
    check("arst_busy",  int'(sif.busy),    0);
    check("arst_enb",   int'(sif.cnt_enb), 0);
    sif.req = 2'b00;
    repeat (2) @(negedge clk);
    check("arst_q_hold", int'(ctr_q), q_at_rst);
    #2 rst = 1'b1;
    tick();
    sif.start0 = 4'd6;
    sif.end0   = 4'd6;
    sif.start1 = 4'd6;
    sif.end1   = 4'd6;
    sif.req    = 2'b11;
    expect_done(1'b0, cyc + 3, 4'd6, 4'd6);
    wait_drain(20);
    sif.req = 2'b00;

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("end_idle", int'(sif.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
